multiplier_seq: RTL and testbench

//  Iterative signed multiplier, the inverse datapath of the signed divider.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/multiplier_seq.sv | 122 ++++++++++++
 tb/tb_multiplier_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
// Contents: FSM state enum, widest supported operand width, magnitude and
//           two's-complement negation helpers sized for that widest case.
package mul_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

   // Helpers work at the widest legal operand width; callers sign-extend
   // in and slice out, so one function body serves every DATA_LEN.
   localparam int MAX_LEN = 64;

   // Magnitude of a signed value as unsigned; the most negative value maps
   // to 2^(MAX_LEN-1), which is still representable as unsigned.
   function automatic logic [MAX_LEN-1:0] abs_u(input logic signed [MAX_LEN-1:0] v);
      return v[MAX_LEN-1] ? (~v + MAX_LEN'(1)) : v;
   endfunction

   // Two's-complement negation of a double-width product.
   function automatic logic [2*MAX_LEN-1:0] neg2n(input logic [2*MAX_LEN-1:0] v);
      return ~v + (2*MAX_LEN)'(1);
   endfunction

endpackage

// File: rtl/multiplier_seq.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one bit per
// cycle, sign applied to the full 2*DATA_LEN product on the last step.
// Ports: clk/reset (sync, active-low); in_valid/in_ready/a/b operand side;
//        out_valid/out_ready/product_lo/product_hi/overflow result side.
// Latency: out_valid after DATA_LEN+1 edges counting the accepting edge;
//          out_ready low holds the result; in_valid ignored while busy.
module multiplier_seq
   import mul_pkg::*;
#(
   parameter int DATA_LEN = 32
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] product_lo,
   output logic [DATA_LEN-1:0] product_hi,
   output logic                overflow
);

   localparam int N  = DATA_LEN;
   localparam int CW = $clog2(DATA_LEN + 1);
   localparam int W2 = 2 * MAX_LEN;
   localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

   mul_state_t state, state_nxt;

   logic [N-1:0]   mcand;
   logic [N-1:0]   mplr;
   logic [2*N-1:0] acc;
   logic           sign;
   logic [CW-1:0]  cnt;

   logic signed [MAX_LEN-1:0] a_ext, b_ext;
   logic [MAX_LEN-1:0]        a_mag_w, b_mag_w;
   logic [N:0]                sum;
   logic [2*N-1:0]            acc_step;
   logic [W2-1:0]             neg_w;
   logic [2*N-1:0]            prod_fin;
   logic                      ovf_fin;

   // Datapath for one CALC step plus the final sign/overflow fix-up. The
   // step result is used directly on the last cycle so the product lands
   // in the output registers on the same edge that enters DONE.
   always_comb begin
      a_ext    = MAX_LEN'($signed(a));
      b_ext    = MAX_LEN'($signed(b));
      a_mag_w  = abs_u(a_ext);
      b_mag_w  = abs_u(b_ext);
      sum      = {1'b0, acc[2*N-1:N]} + (mplr[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      // carry from the add becomes the new top bit after the right shift
      acc_step = {sum, acc[N-1:1]};
      neg_w    = neg2n(W2'(acc_step));
      prod_fin = sign ? neg_w[2*N-1:0] : acc_step;
      ovf_fin  = (prod_fin[2*N-1:N] != {N{prod_fin[N-1]}});
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = CALC;
         end
         CALC: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // return to IDLE only; a new operand is taken on the next edge
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         mcand      <= '0;
         mplr       <= '0;
         acc        <= '0;
         sign       <= 1'b0;
         cnt        <= '0;
         product_lo <= '0;
         product_hi <= '0;
         overflow   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= a_mag_w[N-1:0];
                  mplr  <= b_mag_w[N-1:0];
                  sign  <= a[N-1] ^ b[N-1];
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               acc  <= acc_step;
               mplr <= mplr >> 1;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  product_lo <= prod_fin[N-1:0];
                  product_hi <= prod_fin[2*N-1:N];
                  overflow   <= ovf_fin;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_seq.sv
// Bench for multiplier_seq: 8-bit instance driven from a table of known
// products plus stall/reset sequences; 32-bit instance driven with random
// and corner operands back-to-back against a plain-arithmetic model.
module tb_multiplier_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic       iv8, ir8, ov8, or8, ovf8;
   logic [7:0] a8, b8, lo8, hi8;

   logic        iv32, ir32, ov32, or32, ovf32;
   logic [31:0] a32, b32, lo32, hi32;

   multiplier_seq #(.DATA_LEN(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .product_lo(lo8), .product_hi(hi8),
      .overflow(ovf8)
   );

   multiplier_seq #(.DATA_LEN(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .out_valid(ov32), .out_ready(or32), .product_lo(lo32), .product_hi(hi32),
      .overflow(ovf32)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       ovf;
   } vec8_t;

   // One 8-bit operation. Latency counts the accepting edge as edge 1.
   // During CALC/DONE in_valid stays high with junk operands to show they
   // are ignored. hold = number of extra DONE cycles with out_ready low.
   task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input int hold,
                      output logic [7:0] lo, output logic [7:0] hi, output logic ovf);
      int w;
      int lat;
      @(negedge clk);
      w = 0;
      while (!ir8 && w < 50) begin @(negedge clk); w++; end
      chk("in_ready8_before_op", 64'(ir8), 64'd1);
      a8 = ai; b8 = bi; iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk); lat = 1;
      #1 a8 = 8'($urandom); b8 = 8'($urandom);
      while (!ov8 && lat < 60) begin
         @(posedge clk); lat++;
         #1 a8 = 8'($urandom); b8 = 8'($urandom);
      end
      chk("out_valid8_seen", 64'(ov8), 64'd1);
      chk("latency8", 64'(lat), 64'd9);
      lo = lo8; hi = hi8; ovf = ovf8;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk("hold_lo8", 64'(lo8), 64'(lo));
         chk("hold_hi8", 64'(hi8), 64'(hi));
         chk("hold_ovf8", 64'(ovf8), 64'(ovf));
         chk("hold_out_valid8", 64'(ov8), 64'd1);
         chk("hold_in_ready8", 64'(ir8), 64'd0);
      end
      @(negedge clk);
      or8 = 1'b1; iv8 = 1'b0;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk("post_hs_in_ready8", 64'(ir8), 64'd1);
      chk("post_hs_out_valid8", 64'(ov8), 64'd0);
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   localparam int NR = 1500;

   initial begin
      vec8_t      tbl[12];
      logic [7:0] lo, hi;
      logic       ovf;
      logic [31:0] qa[$], qb[$];
      int          qacc[$];
      int          sent, got, last_acc;

      tbl[0]  = '{8'd7,   8'hFD, 8'hEB, 8'hFF, 1'b0};  //    7 *   -3 =   -21
      tbl[1]  = '{8'h80,  8'hFF, 8'h80, 8'h00, 1'b1};  // -128 *   -1 =   128
      tbl[2]  = '{8'd127, 8'd127,8'h01, 8'h3F, 1'b1};  //  127 *  127 = 16129
      tbl[3]  = '{8'h80,  8'h80, 8'h00, 8'h40, 1'b1};  // -128 * -128 = 16384
      tbl[4]  = '{8'd3,   8'd5,  8'h0F, 8'h00, 1'b0};
      tbl[5]  = '{8'd0,   8'h80, 8'h00, 8'h00, 1'b0};  // zero, negative sign
      tbl[6]  = '{8'hFF,  8'hFF, 8'h01, 8'h00, 1'b0};  //   -1 *   -1
      tbl[7]  = '{8'hFF,  8'd1,  8'hFF, 8'hFF, 1'b0};  //   -1 *    1
      tbl[8]  = '{8'h80,  8'd1,  8'h80, 8'hFF, 1'b0};  // -128 *    1
      tbl[9]  = '{8'hF9,  8'd6,  8'hD6, 8'hFF, 1'b0};  //   -7 *    6 =   -42
      tbl[10] = '{8'd16,  8'd8,  8'h80, 8'h00, 1'b1};  //  +128 overflows
      tbl[11] = '{8'hF0,  8'd8,  8'h80, 8'hFF, 1'b0};  //  -128 fits

      reset = 1'b0;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
      iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready8", 64'(ir8), 64'd1);
      chk("rst_out_valid8", 64'(ov8), 64'd0);
      chk("rst_prod8", {48'd0, hi8, lo8}, 64'd0);
      chk("rst_ovf8", 64'(ovf8), 64'd0);
      chk("rst_in_ready32", 64'(ir32), 64'd1);
      chk("rst_out_valid32", 64'(ov32), 64'd0);
      chk("rst_prod32", {hi32, lo32}, 64'd0);
      chk("rst_ovf32", 64'(ovf32), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table of known 8-bit products.
      for (int i = 0; i < 12; i++) begin
         op8(tbl[i].a, tbl[i].b, 0, lo, hi, ovf);
         chk($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
         chk($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
         chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
      end

      // Outputs keep the last result while idle.
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hold_lo8", 64'(lo8), 64'h80);
      chk("idle_hold_hi8", 64'(hi8), 64'hFF);

      // Consumer stalls five cycles in DONE.
      op8(8'd7, 8'hFD, 5, lo, hi, ovf);
      chk("stall_lo", 64'(lo), 64'hEB);
      chk("stall_hi", 64'(hi), 64'hFF);

      // Reset in the middle of CALC after four steps.
      op8(8'd127, 8'd127, 0, lo, hi, ovf);
      @(negedge clk);
      a8 = 8'd100; b8 = 8'd100; iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid8", 64'(ov8), 64'd0);
      chk("midrst_in_ready8", 64'(ir8), 64'd1);
      chk("midrst_prod8", {48'd0, hi8, lo8}, 64'd0);
      chk("midrst_ovf8", 64'(ovf8), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_no_stale_valid8", 64'(ov8), 64'd0);
      op8(8'd3, 8'd5, 0, lo, hi, ovf);
      chk("after_rst_lo", 64'(lo), 64'h0F);
      chk("after_rst_hi", 64'(hi), 64'h00);
      chk("after_rst_ovf", 64'(ovf), 64'd0);

      // 32-bit back-to-back random run with out_ready held high.
      or32 = 1'b1;
      sent = 0; got = 0; last_acc = 0;
      for (int t = 0; t < NR * 40 && got < NR; t++) begin
         @(negedge clk);
         if (ov32) begin
            if (qa.size() == 0) begin
               chk("unexpected_out32", 64'd1, 64'd0);
            end else begin
               logic [31:0] ea, eb;
               int          acc_at;
               longint      p;
               logic        eovf;
               ea = qa.pop_front(); eb = qb.pop_front(); acc_at = qacc.pop_front();
               p = longint'($signed(ea)) * longint'($signed(eb));
               eovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
               chk($sformatf("prod32 %0h*%0h", ea, eb), {hi32, lo32}, 64'(p));
               chk($sformatf("ovf32 %0h*%0h", ea, eb), 64'(ovf32), 64'(eovf));
               chk("latency32", 64'(cyc - acc_at + 1), 64'd33);
               got++;
            end
         end
         if (ir32 && sent < NR) begin
            logic [31:0] na, nb;
            na = pick32(); nb = pick32();
            a32 = na; b32 = nb; iv32 = 1'b1;
            qa.push_back(na); qb.push_back(nb); qacc.push_back(cyc + 1);
            if (sent > 0) chk("period32", 64'(cyc + 1 - last_acc), 64'd34);
            last_acc = cyc + 1;
            sent++;
         end else begin
            a32 = $urandom(); b32 = $urandom();
            iv32 = (sent < NR);
         end
      end
      chk("results32_received", 64'(got), 64'(NR));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
